// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritises events, flushes the pipeline,
// strobes CP0 EXL set/clear and redirects fetch to the handler or saved EPC.
// Ports: clk, rst (sync, active high); event inputs int_req, exc_adel,
//   exc_ri, exc_ov, exc_ades, eret, stall_in; pc_cur, epc_in.
//   Outputs (all registered): flush, exl_set, exl_clr, pc_redirect,
//   redirect_pc, epc_out, exc_code, in_handler, double_fault, busy.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00004180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        exc_adel,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_ades,
  input  logic        eret,
  input  logic        stall_in,
  input  logic [31:0] pc_cur,
  input  logic [31:0] epc_in,
  output logic        flush,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_out,
  output logic [4:0]  exc_code,
  output logic        in_handler,
  output logic        double_fault,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    VECTOR = 2'd2,
    RET    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        flush_d, exl_set_d, exl_clr_d;
  logic        redir_d, in_h_d, df_d;
  logic [31:0] rpc_d, epc_d;
  logic [4:0]  code_d;

  logic        sync_exc;
  logic [4:0]  sync_code;

  assign sync_exc = exc_adel | exc_ri | exc_ov | exc_ades;

  // Fixed priority among synchronous exceptions.
  always_comb begin
    sync_code = 5'd5;
    if (exc_adel)    sync_code = 5'd4;
    else if (exc_ri) sync_code = 5'd10;
    else if (exc_ov) sync_code = 5'd12;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    exl_set_d = 1'b0;
    exl_clr_d = 1'b0;
    redir_d   = 1'b0;
    rpc_d     = redirect_pc;
    epc_d     = epc_out;
    code_d    = exc_code;
    in_h_d    = in_handler;
    df_d      = double_fault;
    unique case (state_q)
      IDLE: begin
        if (!stall_in) begin
          if (sync_exc && in_handler) begin
            df_d = 1'b1;
          end else if (sync_exc || (int_req && !in_handler)) begin
            epc_d   = pc_cur;
            code_d  = sync_exc ? sync_code : 5'd0;
            flush_d = 1'b1;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end else if (eret && in_handler) begin
            exl_clr_d = 1'b1;
            redir_d   = 1'b1;
            rpc_d     = epc_in;
            flush_d   = 1'b1;
            state_d   = RET;
          end
        end
      end
      FLUSH: begin
        // flush drops on the same edge exl_set rises so the
        // flush width is exactly FLUSH_CYCLES.
        if (cnt_q == 4'd0) begin
          exl_set_d = 1'b1;
          state_d   = VECTOR;
        end else begin
          flush_d = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      VECTOR: begin
        redir_d = 1'b1;
        rpc_d   = HANDLER_ADDR;
        in_h_d  = 1'b1;
        state_d = IDLE;
      end
      RET: begin
        in_h_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      flush        <= 1'b0;
      exl_set      <= 1'b0;
      exl_clr      <= 1'b0;
      pc_redirect  <= 1'b0;
      redirect_pc  <= 32'd0;
      epc_out      <= 32'd0;
      exc_code     <= 5'd0;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush        <= flush_d;
      exl_set      <= exl_set_d;
      exl_clr      <= exl_clr_d;
      pc_redirect  <= redir_d;
      redirect_pc  <= rpc_d;
      epc_out      <= epc_d;
      exc_code     <= code_d;
      in_handler   <= in_h_d;
      double_fault <= df_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule
